capture_dump_cntrl: RTL and testbench

- Sequences read-out of the circular capture RAMs after a capture completes.
- On a dump request it reads all ENTRIES samples of one selected channel, oldest first, starting at the capture write pointer and wrapping at ENTRIES-1.
- Each byte is handed to the UART transmitter through a trmt/tx_done handshake.
- Sits between cmd_cfg, the capture RAMs and the UART transmitter; clears capture_done when the dump finishes.

---
 rtl/capture_dump_cntrl.sv | 135 +++++++++++++
 tb/tb_capture_dump_cntrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_dump_cntrl.sv
// Dump sequencer: reads one channel of the circular capture RAMs oldest-first,
// starting at the write pointer, and hands each byte to the UART via trmt/tx_done.
module capture_dump_cntrl #(
  parameter int ENTRIES  = 384,
  parameter int LOG2     = 9,
  parameter int CHANNELS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dump_req,
  input  logic [2:0]            dump_chan,
  input  logic                  capture_done,
  input  logic [LOG2-1:0]       waddr,
  input  logic [8*CHANNELS-1:0] rdata,
  input  logic                  tx_done,
  output logic [LOG2-1:0]       raddr,
  output logic                  ren,
  output logic [7:0]            tx_data,
  output logic                  trmt,
  output logic                  dump_busy,
  output logic                  dump_done,
  output logic                  clr_capture_done,
  output logic                  dump_nack
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    CAPT   = 3'd2,
    XMIT   = 3'd3,
    WAITTX = 3'd4
  } state_t;

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  state_t          state_q;
  logic [LOG2-1:0] count_q;
  logic [2:0]      chan_q;
  logic [LOG2-1:0] raddr_q;
  logic            ren_q;
  logic [7:0]      tx_data_q;
  logic            trmt_q;
  logic            busy_q;
  logic            done_q;
  logic            clr_q;
  logic            nack_q;

  logic            chan_ok_d;
  logic            waddr_ok_d;
  logic [LOG2-1:0] raddr_nxt_d;
  logic [7:0]      slice_d;

  // Request qualification, circular address step and channel byte select
  always_comb begin
    chan_ok_d   = (int'(dump_chan) < CHANNELS);
    waddr_ok_d  = (int'(waddr) < ENTRIES);
    raddr_nxt_d = (raddr_q == LAST) ? {LOG2{1'b0}} : raddr_q + LOG2'(1);
    slice_d     = 8'h00;
    for (int k = 0; k < CHANNELS; k++) begin
      slice_d = (chan_q == 3'(k)) ? rdata[8*k +: 8] : slice_d;
    end
  end

  // Dump FSM with all outputs registered; strobes default low every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= {LOG2{1'b0}};
      chan_q    <= 3'd0;
      raddr_q   <= {LOG2{1'b0}};
      ren_q     <= 1'b0;
      tx_data_q <= 8'h00;
      trmt_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clr_q     <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      ren_q  <= 1'b0;
      trmt_q <= 1'b0;
      done_q <= 1'b0;
      clr_q  <= 1'b0;
      nack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dump_req) begin
            if (capture_done && chan_ok_d) begin
              chan_q  <= dump_chan;
              raddr_q <= waddr_ok_d ? waddr : {LOG2{1'b0}};
              count_q <= {LOG2{1'b0}};
              busy_q  <= 1'b1;
              ren_q   <= 1'b1;
              state_q <= READ;
            end else begin
              nack_q <= 1'b1;
            end
          end
        end
        READ: state_q <= CAPT;
        CAPT: begin
          tx_data_q <= slice_d;
          trmt_q    <= 1'b1;
          state_q   <= XMIT;
        end
        XMIT: state_q <= WAITTX;
        WAITTX: begin
          if (tx_done) begin
            if (count_q == LAST) begin
              done_q  <= 1'b1;
              clr_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              count_q <= count_q + LOG2'(1);
              raddr_q <= raddr_nxt_d;
              ren_q   <= 1'b1;
              state_q <= READ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign raddr            = raddr_q;
  assign ren              = ren_q;
  assign tx_data          = tx_data_q;
  assign trmt             = trmt_q;
  assign dump_busy        = busy_q;
  assign dump_done        = done_q;
  assign clr_capture_done = clr_q;
  assign dump_nack        = nack_q;

endmodule

// File: tb/tb_capture_dump_cntrl.sv
// Bench for capture_dump_cntrl: RAM model, UART responder, and a dump-level
// reference model (expected address/byte lists) checked every cycle.
module tb_capture_dump_cntrl;
  localparam int N  = 384;
  localparam int LG = 9;
  localparam int CH = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          main_req = 1'b0, noise_req = 1'b0;
  logic          dump_req;
  logic [2:0]    dump_chan = 3'd0;
  logic          capture_done = 1'b0;
  logic [LG-1:0] waddr = '0;
  logic [8*CH-1:0] rdata = '0;
  logic          resp_td = 1'b0, main_td = 1'b0;
  logic          tx_done;
  logic [LG-1:0] raddr;
  logic          ren, trmt, dump_busy, dump_done, clr_capture_done, dump_nack;
  logic [7:0]    tx_data;

  assign dump_req = main_req | noise_req;
  assign tx_done  = resp_td | main_td;

  capture_dump_cntrl #(.ENTRIES(N), .LOG2(LG), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .dump_req(dump_req), .dump_chan(dump_chan),
    .capture_done(capture_done), .waddr(waddr), .rdata(rdata), .tx_done(tx_done),
    .raddr(raddr), .ren(ren), .tx_data(tx_data), .trmt(trmt), .dump_busy(dump_busy),
    .dump_done(dump_done), .clr_capture_done(clr_capture_done), .dump_nack(dump_nack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // capture RAMs: synchronous read, one cycle latency
  logic [7:0] mem [CH][N];
  always @(posedge clk) begin
    if (ren) begin
      for (int k = 0; k < CH; k++) rdata[8*k +: 8] <= mem[k][raddr];
    end
  end

  // reference model state
  bit         m_busy = 0, m_done = 0, m_nack = 0, real_done = 0;
  int         m_bytes = 0, m_id = 0;
  int         exp_addr [N];
  logic [7:0] exp_byte [N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_nack = 0; m_bytes = 0;
    end else begin
      m_done = 0; m_nack = 0;
      if (dump_req && !m_busy) begin
        if (capture_done && dump_chan < CH) begin
          int ws;
          ws = (waddr >= N) ? 0 : int'(waddr);
          for (int i = 0; i < N; i++) begin
            exp_addr[i] = (ws + i) % N;
            exp_byte[i] = mem[dump_chan][exp_addr[i]];
          end
          m_busy = 1; m_bytes = 0; m_id++;
        end else begin
          m_nack = 1;
        end
      end else if (real_done && m_busy) begin
        m_bytes++;
        if (m_bytes == N) begin
          m_done = 1; m_busy = 0;
        end
      end
    end
  end

  // per-cycle compare against the model
  int         ren_idx = 0, trmt_idx = 0, seen_id = 0, dumps = 0;
  int         log_addr [N];
  logic [7:0] log_data [N];
  always @(negedge clk) begin
    if (!rst) begin
      if (m_id != seen_id) begin
        seen_id = m_id; ren_idx = 0; trmt_idx = 0;
      end
      chk("busy", dump_busy, m_busy);
      chk("done", dump_done, m_done);
      chk("clr", clr_capture_done, m_done);
      chk("nack", dump_nack, m_nack);
      if (!m_busy) begin
        chk("ren_idle", ren, 0);
        chk("trmt_idle", trmt, 0);
      end
      if (ren) begin
        if (ren_idx < N) begin
          chk("raddr", raddr, exp_addr[ren_idx]);
          log_addr[ren_idx] = raddr;
        end else chk("ren_extra", ren_idx, N - 1);
        ren_idx++;
      end
      if (trmt) begin
        chk("trmt_after_ren", trmt_idx < ren_idx, 1);
        if (trmt_idx < N) begin
          chk("tx_data", tx_data, exp_byte[trmt_idx]);
          log_data[trmt_idx] = tx_data;
        end else chk("trmt_extra", trmt_idx, N - 1);
        trmt_idx++;
      end
      if (m_done) begin
        chk("trmt_total", trmt_idx, N);
        chk("ren_total", ren_idx, N);
        dumps++;
      end
    end
  end

  // UART responder: tx_done some cycles after trmt, optional stray pulse later
  int resp_fixed = 5;
  bit stray_en = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (trmt && !rst) begin
        int d;
        d = (resp_fixed > 0) ? resp_fixed : int'($urandom_range(1, 6));
        repeat (d) @(posedge clk);
        #1 resp_td = 1'b1; real_done = 1;
        @(posedge clk);
        #1 resp_td = 1'b0; real_done = 0;
        if (stray_en && $urandom_range(0, 1) == 1) begin
          @(posedge clk);
          #1 resp_td = 1'b1;
          @(posedge clk);
          #1 resp_td = 1'b0;
        end
      end
    end
  end

  // requests every 10 cycles while a dump is in progress
  bit noise_en = 0;
  int ncnt = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ncnt++;
      noise_req = (noise_en && m_busy && (ncnt % 10 == 0));
    end
  end

  task automatic req(input logic [2:0] ch, input logic [LG-1:0] wa, input logic cd);
    @(posedge clk);
    #1 main_req = 1'b1; dump_chan = ch; waddr = wa; capture_done = cd;
    @(posedge clk);
    #1 main_req = 1'b0;
  endtask

  task automatic wait_done();
    int start;
    bit ok;
    start = dumps;
    ok = 0;
    for (int i = 0; i < 8000 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (dumps > start) ok = 1;
    end
    chk("dump_finished", ok, 1);
  endtask

  initial begin
    for (int c = 0; c < CH; c++)
      for (int a = 0; a < N; a++)
        mem[c][a] = (c == 0) ? 8'(a) : 8'($urandom);

    #2 rst = 1'b1;
    #1;
    chk("rst_busy", dump_busy, 0);
    chk("rst_ren", ren, 0);
    chk("rst_trmt", trmt, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_txdata", tx_data, 0);
    chk("rst_done", {dump_done, clr_capture_done, dump_nack}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // stray tx_done in IDLE, then channel 0 dump with fixed 5-cycle UART
    main_td = 1'b1;
    @(posedge clk);
    #1 main_td = 1'b0;
    req(3'd0, 9'd0, 1'b1);
    main_td = 1'b1;
    @(negedge clk);
    chk("lat_c1_ren", ren, 1);
    chk("lat_c1_trmt", trmt, 0);
    @(negedge clk);
    chk("lat_c2_ren", ren, 0);
    chk("lat_c2_trmt", trmt, 0);
    @(posedge clk);
    #1 main_td = 1'b0;
    @(negedge clk);
    chk("lat_c3_trmt", trmt, 1);
    chk("lat_c3_data", tx_data, 8'h00);
    wait_done();
    chk("t1_byte0", log_data[0], 8'h00);
    chk("t1_byte127", log_data[127], 8'h7F);
    chk("t1_byte128", log_data[128], 8'h80);
    chk("t1_byte383", log_data[383], 8'h7F);
    chk("t1_addr383", log_addr[383], 383);
    @(negedge clk);
    chk("t1_busy_after", dump_busy, 0);

    // wrap from 380 on channel 2, random UART timing, strays and ignored requests
    resp_fixed = 0;
    stray_en = 1;
    noise_en = 1;
    req(3'd2, 9'd380, 1'b1);
    wait_done();
    noise_en = 0;
    chk("t2_addr0", log_addr[0], 380);
    chk("t2_addr3", log_addr[3], 383);
    chk("t2_addr4", log_addr[4], 0);
    chk("t2_addr383", log_addr[383], 379);
    chk("t2_data0", log_data[0], mem[2][380]);

    // rejected requests
    req(3'd0, 9'd0, 1'b0);
    @(negedge clk);
    chk("nack_cd0", dump_nack, 1);
    chk("nack_cd0_busy", dump_busy, 0);
    req(3'd5, 9'd0, 1'b1);
    @(negedge clk);
    chk("nack_ch5", dump_nack, 1);
    req(3'd7, 9'd10, 1'b1);
    @(negedge clk);
    chk("nack_ch7", dump_nack, 1);
    repeat (5) @(negedge clk);

    // out-of-range write pointer starts at 0
    req(3'd4, 9'd500, 1'b1);
    wait_done();
    chk("t5_addr0", log_addr[0], 0);

    // random dumps
    for (int r = 0; r < 2; r++) begin
      logic [2:0] ch;
      logic [LG-1:0] wa;
      ch = 3'($urandom_range(0, CH - 1));
      wa = LG'($urandom_range(0, N - 1));
      req(ch, wa, 1'b1);
      wait_done();
      chk("rand_addr0", log_addr[0], wa);
    end

    // reset after the 100th tx_done aborts the dump
    begin
      bit hit;
      hit = 0;
      req(3'd1, 9'd200, 1'b1);
      for (int i = 0; i < 4000 && !hit; i++) begin
        @(negedge clk);
        if (m_bytes >= 100) hit = 1;
      end
      chk("reach_100", hit, 1);
      rst = 1'b1;
      #1;
      chk("abort_busy", dump_busy, 0);
      chk("abort_ren", ren, 0);
      chk("abort_trmt", trmt, 0);
      chk("abort_raddr", raddr, 0);
      chk("abort_strobes", {dump_done, clr_capture_done, dump_nack}, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(negedge clk);
      req(3'd3, 9'd77, 1'b1);
      wait_done();
      chk("restart_addr0", log_addr[0], 77);
      chk("restart_data0", log_data[0], mem[3][77]);
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
